// File: rtl/branch_pkg.sv
// Shared types for the execute-side branch resolver.
// Slot layouts follow the decode and execute pipeline registers.
package branch_pkg;

  localparam int IP_W_DEF = 16;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [IP_W_DEF-1:0] ip;
    logic                pred;
  } d_slot_t;

  typedef struct packed {
    logic                valid;
    logic [IP_W_DEF-1:0] ip;
    logic                pred;
    logic                is_branch;
    logic [IP_W_DEF-1:0] target;
  } e_slot_t;

endpackage

// File: rtl/sat_event_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Synchronous active-low reset.
module sat_event_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves predicted branches at execute, trains the predictor,
// and redirects/flushes the front end on a mispredict.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int IP_W         = IP_W_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            CLOCK_50,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            valid_f,
  input  logic [IP_W-1:0] IP_f,
  input  logic            prediction,
  input  logic            isBranch_d,
  input  logic [IP_W-1:0] target_d,
  input  logic            cond_e,
  output logic            wouldExecute,
  output logic [IP_W-1:0] expectedIP,
  output logic            willJump,
  output logic            didJump,
  output logic             flush,
  output logic             redirectValid,
  output logic [IP_W-1:0]  redirectIP,
  output logic [CNT_W-1:0] predCount,
  output logic [CNT_W-1:0] mispredCount
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  state_t         state;
  d_slot_t        d;
  e_slot_t        e;
  logic [FCW-1:0] flush_cnt;
  logic           resolve;
  logic           mispredict;

  assign wouldExecute = e.valid && !stall && (state == RUN);
  assign expectedIP   = e.ip;
  assign willJump     = e.is_branch;
  assign didJump      = e.is_branch && cond_e;
  assign resolve      = wouldExecute && e.is_branch;
  assign mispredict   = resolve && (cond_e != e.pred);

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state         <= RUN;
      d             <= '0;
      e             <= '0;
      flush         <= 1'b0;
      flush_cnt     <= '0;
      redirectValid <= 1'b0;
      redirectIP    <= '0;
    end else begin
      redirectValid <= 1'b0;
      unique case (state)
        RUN: begin
          if (mispredict) begin
            d.valid       <= 1'b0;
            e.valid       <= 1'b0;
            redirectIP    <= cond_e ? e.target : e.ip + 1'b1;
            redirectValid <= 1'b1;
            flush         <= 1'b1;
            flush_cnt     <= FCW'(FLUSH_CYCLES);
            state         <= FLUSH;
          end else if (!stall) begin
            d.valid     <= valid_f;
            d.ip        <= IP_f;
            d.pred      <= prediction;
            e.valid     <= d.valid;
            e.ip        <= d.ip;
            e.pred      <= d.pred && isBranch_d;
            e.is_branch <= isBranch_d;
            e.target    <= target_d;
          end
        end
        FLUSH: begin
          d.valid <= 1'b0;
          e.valid <= 1'b0;
          if (flush_cnt == FCW'(1)) begin
            flush <= 1'b0;
            state <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  sat_event_counter #(.CNT_W(CNT_W)) u_pred_cnt (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .inc   (resolve),
    .count (predCount)
  );

  sat_event_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .inc   (mispredict),
    .count (mispredCount)
  );

endmodule
